// File: rtl/vram_write_arbiter_if.sv
// Requester beat bus plus the registered framebuffer write port shared with vga_adapter.
// slave is the arbiter side; master is the drawer side that also observes the write port.
interface vram_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XW   = 10,
  parameter int YW   = 9,
  parameter int CW   = 9
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ*YW-1:0] req_y;
  logic [NREQ*CW-1:0] req_color;
  logic [NREQ-1:0]    req_ready;

  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_color;
  logic               vga_write;

  modport slave (
    input  req_valid, req_last, req_x, req_y, req_color,
    output req_ready,
    output vga_x, vga_y, vga_color, vga_write
  );

  modport master (
    output req_valid, req_last, req_x, req_y, req_color,
    input  req_ready,
    input  vga_x, vga_y, vga_color, vga_write
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Burst-granular round-robin arbiter for the single framebuffer write port.
// Non-maze drawers are held off until maze_done; beats pass through one register stage.
module vram_write_arbiter #(
  parameter int NREQ = 3,
  parameter int XW   = 10,
  parameter int YW   = 9,
  parameter int CW   = 9
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  maze_done,
  vram_write_arbiter_if.slave   bus,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_next;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   winner;
  logic [PW:0]     idx;

  logic            xfer;
  logic            xfer_last;
  logic [XW-1:0]   sel_x;
  logic [YW-1:0]   sel_y;
  logic [CW-1:0]   sel_color;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i] & ((i == 0) | maze_done);
    end
  end

  // Search upward from rr_ptr with an explicit wrap instead of a modulo.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) begin
        idx = idx - (PW+1)'(NREQ);
      end
      if (!found && elig[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  assign rr_next = (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);

  // Grant is one-hot or zero, so a priority-free OR mux suffices.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_x     = bus.req_x[i*XW +: XW];
        sel_y     = bus.req_y[i*YW +: YW];
        sel_color = bus.req_color[i*CW +: CW];
      end
    end
  end

  assign xfer          = |(bus.req_valid & grant);
  assign xfer_last     = |(bus.req_valid & bus.req_last & grant);
  assign bus.req_ready = grant;
  assign busy          = |grant;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
            rr_ptr <= rr_next;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (xfer_last) begin
            grant <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.vga_write <= 1'b0;
      bus.vga_x     <= '0;
      bus.vga_y     <= '0;
      bus.vga_color <= '0;
    end else begin
      bus.vga_write <= xfer;
      if (xfer) begin
        bus.vga_x     <= sel_x;
        bus.vga_y     <= sel_y;
        bus.vga_color <= sel_color;
      end
    end
  end

endmodule
